// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words MSB-first onto a logic-tile configuration chain.
// Define CCFF_LOADER_CRC_EN to add a CRC-16-CCITT over the returning ccff_tail.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              config_enable,
    output logic              ccff_head,
    output logic              ccff_shift,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bits_left,
    output logic [15:0]       tail_crc
);

    localparam int NB_W = $clog2(WORD_W + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE,
        S_ERROR
    } state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [NB_W-1:0]   nbits_q, nbits_d;
    logic [CNT_W-1:0]  bits_left_q, bits_left_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;
    logic              cen_q, cen_d;
    logic              head_q, head_d;
    logic              shift_q, shift_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [TO_W-1:0]   tmo_inc;
    logic [NB_W-1:0]   nbits_dec;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        nbits_d     = nbits_q;
        bits_left_d = bits_left_q;
        tmo_d       = tmo_q;
        done_d      = done_q;
        err_d       = err_q;
        cfg_ready   = 1'b0;
        tmo_inc     = tmo_q + TO_W'(1);
        nbits_dec   = nbits_q - NB_W'(1);

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d     = S_LOAD;
                    bits_left_d = CNT_W'(CHAIN_LEN);
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    tmo_d       = '0;
                end
            end
            S_LOAD: begin
                // Abort wins, so never advertise acceptance in that cycle.
                cfg_ready = ~abort;
                if (abort) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else if (cfg_valid) begin
                    shreg_d = cfg_data;
                    if (bits_left_q < CNT_W'(WORD_W)) begin
                        nbits_d = NB_W'(bits_left_q);
                    end else begin
                        nbits_d = NB_W'(WORD_W);
                    end
                    state_d = S_SHIFT;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TO_W'(TIMEOUT)) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                // The strobe for this cycle is already out, so count the bit.
                shreg_d     = shreg_q << 1;
                bits_left_d = bits_left_q - CNT_W'(1);
                nbits_d     = nbits_dec;
                if (abort) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else if (nbits_dec == '0) begin
                    if (bits_left_d == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        tmo_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        cen_d   = (state_d == S_LOAD) || (state_d == S_SHIFT);
        shift_d = (state_d == S_SHIFT);
        head_d  = shift_d & shreg_d[WORD_W-1];
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            nbits_q     <= '0;
            bits_left_q <= '0;
            tmo_q       <= '0;
            cen_q       <= 1'b0;
            head_q      <= 1'b0;
            shift_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            nbits_q     <= nbits_d;
            bits_left_q <= bits_left_d;
            tmo_q       <= tmo_d;
            cen_q       <= cen_d;
            head_q      <= head_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign config_enable = cen_q;
    assign ccff_head     = head_q;
    assign ccff_shift    = shift_q;
    assign busy          = (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign done          = done_q;
    assign error         = err_q;
    assign bits_left     = bits_left_q;

`ifdef CCFF_LOADER_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic        crc_restart;

    always_comb begin
        crc_restart = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                (state_q == S_ERROR));
        crc_d = crc_q;
        if (crc_restart) begin
            crc_d = 16'hFFFF;
        end else if (shift_q) begin
            crc_d = {crc_q[14:0], 1'b0} ^
                    ({16{crc_q[15] ^ ccff_tail}} & 16'h1021);
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign tail_crc = crc_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign tail_crc    = '0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomised bench for ccff_chain_loader against a queue-based reference model.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 20;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = 8;
    localparam int TIMEOUT   = 10;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_SHIFT = 2;
    localparam int M_DONE  = 3;
    localparam int M_ERR   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [WORD_W-1:0] cfg_data = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic              config_enable;
    logic              ccff_head;
    logic              ccff_shift;
    logic              ccff_tail = 1'b0;
    logic              busy;
    logic              done;
    logic              error;
    logic [CNT_W-1:0]  bits_left;
    logic [15:0]       tail_crc;

    ccff_chain_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W   (WORD_W),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .prog_clk     (clk),
        .pReset       (rst),
        .start        (start),
        .abort        (abort),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .config_enable(config_enable),
        .ccff_head    (ccff_head),
        .ccff_shift   (ccff_shift),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .bits_left    (bits_left),
        .tail_crc     (tail_crc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        c  = c << 1;
        if (fb) c = c ^ 16'h1021;
        return c;
    endfunction

    // Reference model: bits waiting to go out are kept as a plain queue.
    int          m_mode;
    int          m_left;
    int          m_wait;
    bit          m_done;
    bit          m_err;
    logic [15:0] m_crc;
    bit          m_q[$];
    bit          m_stream[$];

    task automatic m_reset();
        m_mode = M_IDLE;
        m_left = 0;
        m_wait = 0;
        m_done = 0;
        m_err  = 0;
        m_crc  = 16'h0000;
        m_q.delete();
    endtask

    task automatic m_step();
        int k;
        bit b;
        case (m_mode)
            M_IDLE, M_DONE, M_ERR: begin
                if (start) begin
                    m_mode = M_LOAD;
                    m_left = CHAIN_LEN;
                    m_done = 0;
                    m_err  = 0;
                    m_wait = 0;
                    m_crc  = 16'hFFFF;
                    m_q.delete();
                end
            end
            M_LOAD: begin
                if (abort) begin
                    m_mode = M_ERR;
                    m_err  = 1;
                end else if (cfg_valid) begin
                    k = (m_left < WORD_W) ? m_left : WORD_W;
                    for (int i = 0; i < k; i++) m_q.push_back(cfg_data[WORD_W-1-i]);
                    m_mode = M_SHIFT;
                end else begin
                    m_wait++;
                    if (m_wait >= TIMEOUT) begin
                        m_mode = M_ERR;
                        m_err  = 1;
                    end
                end
            end
            M_SHIFT: begin
                b = m_q.pop_front();
                m_stream.push_back(b);
                m_crc  = crc_bit(m_crc, ccff_tail);
                m_left = m_left - 1;
                if (abort) begin
                    m_mode = M_ERR;
                    m_err  = 1;
                end else if (m_q.size() == 0) begin
                    if (m_left == 0) begin
                        m_mode = M_DONE;
                        m_done = 1;
                    end else begin
                        m_mode = M_LOAD;
                        m_wait = 0;
                    end
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    int dut_shifts = 0;

    always @(negedge clk) begin
        logic        e_head;
        logic [15:0] e_crc;
        e_head = (m_mode == M_SHIFT && m_q.size() > 0) ? m_q[0] : 1'b0;
`ifdef CCFF_LOADER_CRC_EN
        e_crc = m_crc;
`else
        e_crc = 16'h0000;
`endif
        if (ccff_shift) dut_shifts++;
        chk("cfg_ready", 32'(cfg_ready), 32'(m_mode == M_LOAD && !abort));
        chk("config_enable", 32'(config_enable),
            32'(m_mode == M_LOAD || m_mode == M_SHIFT));
        chk("busy", 32'(busy), 32'(m_mode == M_LOAD || m_mode == M_SHIFT));
        chk("ccff_shift", 32'(ccff_shift), 32'(m_mode == M_SHIFT));
        chk("ccff_head", 32'(ccff_head), 32'(e_head));
        chk("done", 32'(done), 32'(m_done));
        chk("error", 32'(error), 32'(m_err));
        chk("bits_left", 32'(bits_left), 32'(m_left));
        chk("tail_crc", 32'(tail_crc), 32'(e_crc));
    end

    bit tail_rand = 0;
    bit abort_en  = 0;
    bit stray_en  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        ccff_tail = tail_rand ? 1'($urandom % 2) : 1'b0;
        if (abort_en) abort = ($urandom % 64) == 0;
        if (stray_en) start = (m_mode == M_LOAD || m_mode == M_SHIFT) &&
                              (($urandom % 8) == 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w, input int gap);
        int n;
        n = 0;
        cfg_data  = w;
        cfg_valid = (gap == 0);
        while (m_mode == M_SHIFT && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("wait_load_timeout", 32'(n), 32'(0));
        if (m_mode != M_LOAD) begin
            cfg_valid = 1'b0;
            return;
        end
        for (int g = 0; g < gap; g++) begin
            cfg_valid = 1'b0;
            tick();
            if (m_mode != M_LOAD) return;
        end
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        cfg_data  = WORD_W'($urandom);
    endtask

    task automatic wait_term();
        int n;
        n = 0;
        while ((m_mode == M_LOAD || m_mode == M_SHIFT) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) chk("wait_term_timeout", 32'(n), 32'(0));
    endtask

    function automatic logic [31:0] stream_val();
        logic [31:0] v;
        v = '0;
        foreach (m_stream[i]) v = {v[30:0], 1'(m_stream[i])};
        return v;
    endfunction

    task automatic directed_load(input int gap);
        m_stream.delete();
        dut_shifts = 0;
        do_start();
        send_word(8'hA5, gap);
        send_word(8'h3C, gap);
        send_word(8'h9F, gap);
        wait_term();
        tick();
        chk("dir_stream", stream_val(), 32'h000A_53C9);
        chk("dir_nbits", 32'(m_stream.size()), 32'd20);
        chk("dir_shift_count", 32'(dut_shifts), 32'd20);
        chk("dir_done", 32'(done), 32'd1);
        chk("dir_cen_low", 32'(config_enable), 32'd0);
        chk("dir_bits_left", 32'(bits_left), 32'd0);
        chk("dir_ready_low", 32'(cfg_ready), 32'd0);
    endtask

    initial begin
        logic [15:0] c;

        #3;
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_cen", 32'(config_enable), 32'd0);
        chk("rst_shift", 32'(ccff_shift), 32'd0);
        chk("rst_bits_left", 32'(bits_left), 32'd0);
        chk("rst_crc", 32'(tail_crc), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        c = 16'hFFFF;
        for (int i = 0; i < 16; i++) c = crc_bit(c, 1'b0);
        chk("model_crc_zero16", 32'(c), 32'h1D0F);

        directed_load(0);
        directed_load(3);

        do_start();
        repeat (9) tick();
        chk("tmo_before", 32'(error), 32'd0);
        tick();
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_cen", 32'(config_enable), 32'd0);
        do_start();
        chk("tmo_restart_err", 32'(error), 32'd0);
        chk("tmo_restart_busy", 32'(busy), 32'd1);
        send_word(8'h11, 0);
        send_word(8'h22, 0);
        send_word(8'h33, 0);
        wait_term();

        m_stream.delete();
        do_start();
        cfg_data  = 8'hA5;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_error", 32'(error), 32'd1);
        chk("abort_bits_left", 32'(bits_left), 32'd15);
        chk("abort_shift", 32'(ccff_shift), 32'd0);
        chk("abort_stream", stream_val(), 32'h0000_0014);
        repeat (3) tick();

        do_start();
        cfg_data  = 8'hC3;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_shift", 32'(ccff_shift), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cen", 32'(config_enable), 32'd0);
        chk("arst_bits_left", 32'(bits_left), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        tail_rand = 1;
        abort_en  = 1;
        stray_en  = 1;
        for (int r = 0; r < 40; r++) begin
            do_start();
            for (int w = 0; w < 8; w++) begin
                if (m_mode != M_LOAD && m_mode != M_SHIFT) break;
                send_word(WORD_W'($urandom),
                          (($urandom % 10) == 0) ? 12 : int'($urandom % 4));
            end
            wait_term();
            tick();
        end
        abort_en = 0;
        stray_en = 0;
        abort    = 1'b0;
        start    = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain sequencer that takes bitstream words over a valid/ready stream and serialises them MSB-first onto the ccff_head of a logic-tile configuration chain.
- Drives config_enable and a per-bit shift strobe for the chain, counts exactly CHAIN_LEN bits, and reports done, busy, abort or timeout.
- Sits between the bitstream source (SPI or JTAG front end) and the first tile's ccff_head. ccff_tail of the last tile returns to it.

Parameters:
- CHAIN_LEN, 1024, total configuration bits in the chain (≥1).
- WORD_W, 8, input word width (≥1).
- CNT_W, 16, bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.
- TIMEOUT, 4096, maximum consecutive LOAD cycles without cfg_valid before error (≥1).

Ports:
- prog_clk  in  1  programming clock; all state on rising edge.
- pReset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- abort  in  1  level; forces ERROR from LOAD or SHIFT.
- cfg_data  in  WORD_W  bitstream word, MSB shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  word accepted when cfg_valid & cfg_ready.
- config_enable  out  1  chain configuration mode.
- ccff_head  out  1  serial bit into chain.
- ccff_shift  out  1  chain advances on this prog_clk edge.
- ccff_tail  in  1  serial bit out of chain end.
- busy  out  1  high in LOAD or SHIFT.
- done  out  1  sticky; all CHAIN_LEN bits shifted.
- error  out  1  sticky; abort or timeout.
- bits_left  out  CNT_W  bits remaining.
- tail_crc  out  16  CRC of ccff_tail stream (optional feature).

Behaviour:
- Reset values: state IDLE; cfg_ready, config_enable, ccff_head, ccff_shift, busy, done, error all 0; bits_left 0; tail_crc 0. Reset mid-load returns to IDLE immediately, with no further shifts.
- IDLE: outputs at rest. start → LOAD; bits_left ← CHAIN_LEN; done ← 0; error ← 0; timeout counter ← 0; config_enable ← 1.
- LOAD:
  - cfg_ready = 1 combinationally.
  - On handshake: shift register ← cfg_data; nbits ← min(WORD_W, bits_left); go to SHIFT.
  - No valid: timeout counter increments. Reaching TIMEOUT → ERROR.
  - ccff_shift = 0.
- SHIFT:
  - One bit per cycle. ccff_head = shreg MSB; ccff_shift = 1; shreg shifts left; bits_left decrements; nbits decrements.
  - When nbits hits 0: if bits_left = 0, go to DONE; otherwise go to LOAD and clear the timeout counter.
  - cfg_ready = 0.
- Partial last word: if CHAIN_LEN mod WORD_W ≠ 0, only the upper (CHAIN_LEN mod WORD_W) bits of the final word are shifted. The lower bits are discarded.
- Latency: first ccff_shift occurs the cycle after the first handshake. A continuous stream gives a throughput of WORD_W bits per WORD_W+1 cycles.
- DONE: done = 1; config_enable ← 0 on entry; cfg_ready = 0. start restarts the load.
- ERROR: error = 1; config_enable ← 0; ccff_shift = 0. start restarts and clears error.
- abort has priority over the handshake and the timeout in the same cycle. start is ignored in LOAD and SHIFT.
- Word accepted in LOAD after bits_left already reached 0: cannot occur, because DONE is entered first.
- ccff_head and ccff_shift are registered, glitch-free outputs.

Optional Feature:
- CCFF_LOADER_CRC_EN defined:
  - tail_crc is CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over ccff_tail, sampled on every cycle with ccff_shift = 1.
  - Reinitialised to 0xFFFF on start.
  - Frozen in DONE and ERROR.
- Not defined: tail_crc is tied to 0 and no CRC logic is synthesised.

Test Plan:
- CHAIN_LEN=16, WORD_W=8; words 0xA5 then 0x3C back-to-back → ccff_head sequence 1010_0101_0011_1100; exactly 16 ccff_shift cycles; done=1; config_enable falls; bits_left=0.
- CHAIN_LEN=12, WORD_W=8; words 0xFF then 0x9F → 12 shifts, last four bits 1001; done=1; no third cfg_ready.
- CHAIN_LEN=16; valid withheld 3 cycles between words → ccff_shift stays 0 during the gap; output stream identical to the first test.
- TIMEOUT=10; start with no cfg_valid → error=1 after 10 LOAD cycles; config_enable=0; start then restarts with error cleared.
- abort asserted mid-SHIFT after 5 bits → ERROR next cycle; no further ccff_shift; bits_left=11.
- CCFF_LOADER_CRC_EN; ccff_tail held 0 for 16 shifts → tail_crc equals CRC-16-CCITT of 0x0000 with init 0xFFFF = 0x1D0F. pReset mid-shift → all outputs return to reset values asynchronously.
